// File: rtl/key_schedule_seq.sv
// Iterative AES key schedule: expands one 32-bit word per clock through a single 4-byte S-box lane
// and serves round keys through a registered read port. Optional macro: KS_REVERSE_READ_EN.
module key_schedule_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Nk*32-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
`ifdef KS_REVERSE_READ_EN
    input  logic             rk_rd_rev,
`endif
    output logic [127:0]     rk_rd_data,
    output logic             rk_rd_valid
);

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW + 1);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         state_q;
    logic [IW-1:0]  i_q;
    logic [2:0]     wrap_q;
    logic [7:0]     rcon_q;
    logic           busy_q;
    logic           done_q;
    logic           key_valid_q;
    logic           rd_valid_q;
    logic [127:0]   rd_data_q;
    logic [31:0]    w_q [NW];

    logic [IW-1:0]  prev_idx;
    logic [IW-1:0]  back_idx;
    logic [31:0]    prev_word;
    logic [31:0]    sbox_in;
    logic [31:0]    sbox_out;
    logic [31:0]    temp;
    logic [31:0]    word_d;
    logic [3:0]     rd_idx_eff;
    logic [IW-1:0]  rd_base;
    logic           rd_ok;
    logic           accept;

    assign prev_idx  = i_q - IW'(1);
    assign back_idx  = i_q - IW'(Nk);
    assign prev_word = w_q[prev_idx];

    // RotWord is only applied on the Rcon step; the Nk=8 mid-key step substitutes unrotated.
    assign sbox_in = (wrap_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    assign sbox_out[31:24] = sbox(sbox_in[31:24]);
    assign sbox_out[23:16] = sbox(sbox_in[23:16]);
    assign sbox_out[15:8]  = sbox(sbox_in[15:8]);
    assign sbox_out[7:0]   = sbox(sbox_in[7:0]);

    always_comb begin
        temp = prev_word;
        if (wrap_q == 3'd0) begin
            temp = sbox_out ^ {rcon_q, 24'h000000};
        end else if (Nk == 8 && wrap_q == 3'd4) begin
            temp = sbox_out;
        end
    end

    assign word_d = w_q[back_idx] ^ temp;

`ifdef KS_REVERSE_READ_EN
    assign rd_idx_eff = rk_rd_rev ? (4'(Nr) - rk_rd_idx) : rk_rd_idx;
`else
    assign rd_idx_eff = rk_rd_idx;
`endif

    assign rd_base = IW'({rd_idx_eff, 2'b00});
    assign rd_ok   = rk_rd_en && key_valid_q && (rk_rd_idx <= 4'(Nr));
    assign accept  = (state_q == S_IDLE) && start;

    // Buffer is not reset; key_valid gates every read so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                for (int j = 0; j < Nk; j++) begin
                    w_q[j] <= key[(Nk-1-j)*32 +: 32];
                end
            end else if (state_q == S_EXPAND) begin
                w_q[i_q] <= word_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            wrap_q      <= 3'd0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_EXPAND;
                        i_q         <= IW'(Nk);
                        wrap_q      <= 3'd0;
                        rcon_q      <= 8'h01;
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    i_q    <= i_q + IW'(1);
                    wrap_q <= (wrap_q == 3'(Nk - 1)) ? 3'd0 : wrap_q + 3'd1;
                    if (wrap_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (i_q == IW'(NW - 1)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (rd_ok) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= {w_q[rd_base], w_q[rd_base + IW'(1)],
                               w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign key_valid   = key_valid_q;
    assign rk_rd_valid = rd_valid_q;
    assign rk_rd_data  = rd_data_q;

endmodule
